// File: rtl/bumpy_motion_fsm_pkg.sv
// Shared types and index constants for the bumpy ball motion block.
// Edge bits follow the HitEdgeCode layout {Left, Top, Right, Bottom}.
package bumpy_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    AIR      = 2'b01,
    DEAD     = 2'b10
  } motion_state_e;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;
  localparam int NUM_EDGE    = 4;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_JUMP  = 2;
  localparam int NUM_BTN   = 3;

  function automatic logic is_onehot3(input logic [NUM_BTN-1:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/bumpy_motion_fsm_if.sv
// Port bundle between debounce/collision logic, the motion block and the sprite drawer.
// startOfFrame is a one-cycle pulse; buttons/respawn are levels; HitEdgeCode is valid only while collision=1.
interface bumpy_motion_fsm_if #(
  parameter int POS_W = 11
);
  logic                    startOfFrame;
  logic                    right;
  logic                    left;
  logic                    jump;
  logic                    respawn;
  logic                    collision;
  logic [3:0]              HitEdgeCode;
  logic signed [POS_W-1:0] topLeftX;
  logic signed [POS_W-1:0] topLeftY;
  logic [1:0]              state;
  logic                    dead;

  modport master (
    output startOfFrame, right, left, jump, respawn, collision, HitEdgeCode,
    input  topLeftX, topLeftY, state, dead
  );

  modport slave (
    input  startOfFrame, right, left, jump, respawn, collision, HitEdgeCode,
    output topLeftX, topLeftY, state, dead
  );
endinterface

// File: rtl/bumpy_motion_fsm_frame_event_latch.sv
// OR-accumulates N event bits over one frame, optionally on rising edges only.
// On clear the frame total is handed over and the same-cycle events seed the next frame.
module frame_event_latch #(
  parameter int N           = 3,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         sample_en,
  input  logic [N-1:0] in_bits,
  output logic [N-1:0] acc
);

  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] events;

  always_comb begin
    prev_d = in_bits;
    events = EDGE_DETECT ? (in_bits & ~prev_q) : in_bits;
    if (!sample_en) events = '0;
    acc_d = clear ? events : (acc_q | events);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      acc_q  <= '0;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/bumpy_motion_fsm.sv
// Fixed-point ball motion with gravity, button launches and per-edge collision response.
// All motion is applied once per startOfFrame from the events gathered in the previous frame.
module bumpy_motion_fsm
  import bumpy_pkg::*;
#(
  parameter int FRAC_BITS  = 6,
  parameter int POS_W      = 11,
  parameter int SPEED_W    = 12,
  parameter int INITIAL_X  = 100,
  parameter int INITIAL_Y  = 100,
  parameter int GRAVITY    = 10,
  parameter int JUMP_SPEED = 256,
  parameter int HOP_SPEED  = 128,
  parameter int SIDE_SPEED = 160,
  parameter int MAX_FALL   = 512,
  parameter bit BOUNCE_X   = 1'b0,
  parameter int X_MAX      = 607,
  parameter int Y_MAX      = 479
) (
  input logic                clk,
  input logic                resetN,
  bumpy_motion_fsm_if.slave  bus
);

  localparam int PW = POS_W + FRAC_BITS + 1;

  localparam logic signed [PW-1:0]      INIT_PX = PW'(INITIAL_X * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0]      INIT_PY = PW'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0]      X_LIM   = PW'(X_MAX * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0]      Y_LIM   = PW'(Y_MAX * (2 ** FRAC_BITS));
  localparam logic signed [SPEED_W-1:0] JUMP_C  = SPEED_W'(JUMP_SPEED);
  localparam logic signed [SPEED_W-1:0] HOP_C   = SPEED_W'(HOP_SPEED);
  localparam logic signed [SPEED_W-1:0] SIDE_C  = SPEED_W'(SIDE_SPEED);
  localparam logic signed [SPEED_W:0]   GRAV_C  = (SPEED_W+1)'(GRAVITY);
  localparam logic signed [SPEED_W:0]   MAXF_C  = (SPEED_W+1)'(MAX_FALL);

  function automatic logic signed [PW-1:0] sext(input logic signed [SPEED_W-1:0] v);
    return {{(PW-SPEED_W){v[SPEED_W-1]}}, v};
  endfunction

  motion_state_e             state_q, state_d;
  logic signed [PW-1:0]      px_q, px_d, py_q, py_d;
  logic signed [SPEED_W-1:0] xs_q, xs_d, ys_q, ys_d;

  logic signed [SPEED_W-1:0] xs_hit, ys_hit;
  logic signed [SPEED_W:0]   ys_grav;
  logic signed [PW-1:0]      nx, ny;
  logic                      xs_neg, xs_pos, ys_neg;

  logic [NUM_BTN-1:0]  btn_acc;
  logic [NUM_EDGE-1:0] hit_acc;
  logic                sof;

  assign sof = bus.startOfFrame;

  frame_event_latch #(.N(NUM_BTN), .EDGE_DETECT(1'b1)) u_btn_latch (
    .clk       (clk),
    .rst_n     (resetN),
    .clear     (sof),
    .sample_en (1'b1),
    .in_bits   ({bus.jump, bus.left, bus.right}),
    .acc       (btn_acc)
  );

  frame_event_latch #(.N(NUM_EDGE), .EDGE_DETECT(1'b0)) u_hit_latch (
    .clk       (clk),
    .rst_n     (resetN),
    .clear     (sof),
    .sample_en (bus.collision),
    .in_bits   (bus.HitEdgeCode),
    .acc       (hit_acc)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= AIR;
      px_q    <= INIT_PX;
      py_q    <= INIT_PY;
      xs_q    <= '0;
      ys_q    <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xs_neg  = xs_q[SPEED_W-1];
    xs_pos  = !xs_q[SPEED_W-1] && (xs_q != '0);
    ys_neg  = ys_q[SPEED_W-1];
    xs_hit  = xs_q;
    ys_hit  = ys_q;
    nx      = px_q;
    ny      = py_q;
    ys_grav = '0;

    if (sof) begin
      case (state_q)
        GROUNDED: begin
          if (is_onehot3(btn_acc)) begin
            state_d = AIR;
            if (btn_acc[BTN_JUMP]) begin
              xs_d = '0;
              ys_d = -JUMP_C;
            end else if (btn_acc[BTN_RIGHT]) begin
              xs_d = SIDE_C;
              ys_d = -HOP_C;
            end else begin
              xs_d = -SIDE_C;
              ys_d = -HOP_C;
            end
          end else if ((btn_acc == '0) && !hit_acc[EDGE_BOTTOM]) begin
            // Walked off a ledge: start falling from rest.
            state_d = AIR;
            ys_d    = '0;
          end
        end

        AIR: begin
          if (hit_acc[EDGE_BOTTOM] && !ys_neg) begin
            state_d = GROUNDED;
            xs_d    = '0;
            ys_d    = '0;
          end else begin
            if (hit_acc[EDGE_TOP] && ys_neg) ys_hit = '0;
            if ((hit_acc[EDGE_LEFT] && xs_neg) || (hit_acc[EDGE_RIGHT] && xs_pos))
              xs_hit = BOUNCE_X ? -xs_q : '0;
            nx      = px_q + sext(xs_hit);
            ny      = py_q + sext(ys_hit);
            ys_grav = {ys_hit[SPEED_W-1], ys_hit} + GRAV_C;
            px_d    = nx;
            py_d    = ny;
            xs_d    = xs_hit;
            ys_d    = (ys_grav > MAXF_C) ? MAXF_C[SPEED_W-1:0] : ys_grav[SPEED_W-1:0];
            if (nx[PW-1]) begin
              px_d = '0;
              xs_d = '0;
            end else if (nx > X_LIM) begin
              px_d = X_LIM;
              xs_d = '0;
            end
            // Leaving the bottom of the playfield freezes the ball where it was.
            if (ny > Y_LIM) begin
              state_d = DEAD;
              px_d    = px_q;
              py_d    = py_q;
              xs_d    = '0;
              ys_d    = '0;
            end
          end
        end

        DEAD: begin
          if (bus.respawn) begin
            state_d = AIR;
            px_d    = INIT_PX;
            py_d    = INIT_PY;
            xs_d    = '0;
            ys_d    = '0;
          end
        end

        default: state_d = AIR;
      endcase
    end
  end

  // Pixel outputs are the floor of the fixed-point position, taken straight from the registers.
  always_comb begin
    bus.topLeftX = px_q[POS_W+FRAC_BITS-1:FRAC_BITS];
    bus.topLeftY = py_q[POS_W+FRAC_BITS-1:FRAC_BITS];
    bus.state    = state_q;
    bus.dead     = (state_q == DEAD);
  end

endmodule
